// File: rtl/bus_mem.sv
// bus_mem: CPU-attached word memory with boot-image loading and a shared
// tri-state data bus. Boot words are loaded while boot=1; afterwards the CPU
// reads combinationally and writes on the clock edge.
// Optional feature: define BUS_MEM_WRITE_PROTECT_EN to block run-mode writes
// below PROT_LIMIT. Without it every run-mode write commits and err_wp stays 0.
// `WORD_SIZE / `ADDR_SIZE normally come from top_macro.vh; the fallbacks
// below carry the same values so this file also builds on its own.

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module bus_mem #(
  parameter logic [`ADDR_SIZE-1:0] PROT_LIMIT = 8'h40
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`ADDR_SIZE-1:0] addr_bus,
  inout  wire  [`WORD_SIZE-1:0] data_bus,
  input  logic                  wr_en,
  input  logic                  boot,
  input  logic [`WORD_SIZE-1:0] boot_din,
  output logic                  boot_done,
  output logic                  err_misalign,
  output logic                  err_wp,
  output logic [15:0]           wr_cnt
);

  localparam int W     = `WORD_SIZE;
  localparam int A     = `ADDR_SIZE;
  localparam int DEPTH = 2 ** (A - 1);

`ifdef BUS_MEM_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  state_t         state_q, state_d;
  logic           boot_done_q, boot_done_d;
  logic           err_misalign_q, err_misalign_d;
  logic           err_wp_q, err_wp_d;
  logic [15:0]    wr_cnt_q, wr_cnt_d;

  logic [W-1:0]   mem [DEPTH];
  logic [A-2:0]   idx;
  logic           run_access;
  logic           prot_hit;
  logic           mem_we;
  logic [W-1:0]   mem_wdata;

  // Address bit 0 never selects a word; it only flags misalignment.
  assign idx      = addr_bus[A-1:1];
  assign prot_hit = (addr_bus < PROT_LIMIT);

  // Next-state, flag and memory-write decode.
  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d        = state_q;
    boot_done_d    = 1'b0;
    err_misalign_d = err_misalign_q;
    err_wp_d       = err_wp_q;
    wr_cnt_d       = wr_cnt_q;
    mem_we         = 1'b0;
    mem_wdata      = boot_din;

    unique case (state_q)
      S_IDLE: if (boot) state_d = S_LOAD;
      S_LOAD: begin
        if (!boot) begin
          state_d     = S_RUN;
          boot_done_d = 1'b1;
        end
      end
      S_RUN:  if (boot) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase

    // CPU-owned cycle once a boot has happened (includes the LOAD->RUN edge).
    run_access = !boot && (state_q != S_IDLE);

    if (run_access && addr_bus[0]) err_misalign_d = 1'b1;

    if (boot) begin
      mem_we    = 1'b1;
      mem_wdata = boot_din;
    end else if (run_access && wr_en) begin
      if (WP_EN && prot_hit) begin
        err_wp_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_wdata = data_bus;
        if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
      end
    end
  end

  // State, pulse, sticky flags and write counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      boot_done_q    <= 1'b0;
      err_misalign_q <= 1'b0;
      err_wp_q       <= 1'b0;
      wr_cnt_q       <= 16'h0000;
    end else begin
      state_q        <= state_d;
      boot_done_q    <= boot_done_d;
      err_misalign_q <= err_misalign_d;
      err_wp_q       <= err_wp_d;
      wr_cnt_q       <= wr_cnt_d;
    end
  end

  // Storage write port; reset only suppresses the write.
  // NOTE: the array is deliberately not reset, so it maps onto plain RAM and
  // keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[idx] <= mem_wdata;
  end

  // Drive the bus only on a CPU read; stay off it during reset, boot or writes.
  assign data_bus = (!rst && !boot && !wr_en) ? mem[idx] : {W{1'bz}};

  assign boot_done    = boot_done_q;
  assign err_misalign = err_misalign_q;
  assign err_wp       = err_wp_q;
  assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_bus_mem.sv
// tb_bus_mem: randomized self-checking bench for bus_mem. A small
// phase-based reference model (off / booting / running) tracks the expected
// memory image, flags and write count. Whenever the block must keep off the
// bus, the bench drives it itself (write data, or 0 otherwise), so any
// stray drive from the block corrupts the observed value.

module tb_bus_mem;

`ifdef BUS_MEM_WRITE_PROTECT_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif
  localparam logic [7:0] LIMIT = 8'h40;

  logic        clk = 1'b0;
  logic        rst;
  logic        boot;
  logic        wr_en;
  logic [7:0]  addr_bus;
  logic [15:0] boot_din;
  wire  [15:0] data_bus;
  logic        boot_done;
  logic        err_misalign;
  logic        err_wp;
  logic [15:0] wr_cnt;

  logic        tb_drive;
  logic [15:0] tb_data;

  assign data_bus = tb_drive ? tb_data : 16'hzzzz;

  bus_mem #(.PROT_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr_bus     (addr_bus),
    .data_bus     (data_bus),
    .wr_en        (wr_en),
    .boot         (boot),
    .boot_din     (boot_din),
    .boot_done    (boot_done),
    .err_misalign (err_misalign),
    .err_wp       (err_wp),
    .wr_cnt       (wr_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  typedef enum {M_OFF, M_BOOTING, M_RUNNING} mode_t;
  logic [15:0] ref_mem   [128];
  bit          ref_valid [128];
  mode_t       mode      = M_OFF;
  int          exp_cnt   = 0;
  bit          exp_mis   = 1'b0;
  bit          exp_wp    = 1'b0;
  bit          exp_bd    = 1'b0;
  int          bd_pulses = 0;

  // One clock cycle: apply inputs, check at the falling edge, advance the model.
  task automatic step(input bit r, input bit b, input bit w,
                      input logic [7:0] a, input logic [15:0] d, input string tag);
    int k;
    k        = int'(a[7:1]);
    rst      = r;
    boot     = b;
    wr_en    = w;
    addr_bus = a;
    boot_din = d;
    tb_drive = r || b || w;
    tb_data  = w ? d : 16'h0000;
    @(negedge clk);
    if (tb_drive) check({tag, " bus"}, data_bus, tb_data);
    else if (ref_valid[k]) check({tag, " rd"}, data_bus, ref_mem[k]);
    check({tag, " boot_done"}, boot_done, exp_bd);
    check({tag, " err_misalign"}, err_misalign, exp_mis);
    check({tag, " err_wp"}, err_wp, exp_wp);
    check({tag, " wr_cnt"}, wr_cnt, exp_cnt);
    if (boot_done) bd_pulses++;
    @(posedge clk);
    exp_bd = 1'b0;
    if (r) begin
      mode    = M_OFF;
      exp_cnt = 0;
      exp_mis = 1'b0;
      exp_wp  = 1'b0;
    end else if (b) begin
      ref_mem[k]   = d;
      ref_valid[k] = 1'b1;
      mode         = M_BOOTING;
    end else if (mode != M_OFF) begin
      exp_bd = (mode == M_BOOTING);
      mode   = M_RUNNING;
      if (a[0]) exp_mis = 1'b1;
      if (w) begin
        if (WP && a < LIMIT) exp_wp = 1'b1;
        else begin
          ref_mem[k]   = d;
          ref_valid[k] = 1'b1;
          if (exp_cnt < 65535) exp_cnt++;
        end
      end
    end
    #1;
  endtask

  task automatic random_phase(input int n, input bit allow_odd);
    logic [7:0]  a;
    logic [7:0]  last_a;
    logic [15:0] d;
    bit          w;
    last_a = 8'h80;
    for (int i = 0; i < n; i++) begin
      a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = last_a;
      if (!allow_odd) a[0] = 1'b0;
      d = 16'($urandom);
      w = ($urandom_range(0, 9) < 4);
      step(1'b0, 1'b0, w, a, d, "rand");
      if (w) last_a = a;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_valid[i] = 1'b0;
    rst      = 1'b1;
    boot     = 1'b0;
    wr_en    = 1'b0;
    addr_bus = 8'h00;
    boot_din = 16'h0000;
    tb_drive = 1'b1;
    tb_data  = 16'h0000;
    @(posedge clk);
    #1;

    // Reset state and a one-cycle reset
    step(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, "rst");

    // Full boot: addr 0,2..FE with boot_din = addr*3
    for (int i = 0; i < 128; i++)
      step(1'b0, 1'b1, 1'b0, 8'(2 * i), 16'(6 * i), "boot");
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "boot_fall");
    check("boot_done_pulse", boot_done, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "after_done");
    check("boot_done_drop", boot_done, 1'b0);
    check("boot_pulses", bd_pulses, 1);

    // Read back the whole image
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'(2 * i), 16'h0000, "img");
      check("img_word", data_bus, 16'(6 * i));
    end

    // Run write then same-address read
    step(1'b0, 1'b0, 1'b1, 8'h80, 16'hBEEF, "wr80");
    step(1'b0, 1'b0, 0, 8'h80, 16'h0000, "rd80");
    check("beef_read", data_bus, 16'hBEEF);
    check("beef_cnt", wr_cnt, 16'd1);

    // Write below the protection limit
    step(1'b0, 1'b0, 1'b1, 8'h10, 16'h1234, "wr10");
    step(1'b0, 1'b0, 1'b0, 8'h10, 16'h0000, "rd10");
    check("prot_read", data_bus, WP ? 16'h0030 : 16'h1234);
    check("prot_flag", err_wp, WP);
    check("prot_cnt", wr_cnt, WP ? 16'd1 : 16'd2);

    // Aligned random traffic
    random_phase(300, 1'b0);
    check("mis_before", err_misalign, 1'b0);

    // Misaligned read returns the even word and sets the sticky flag
    step(1'b0, 1'b0, 1'b1, 8'h80, 16'hBEEF, "wr80b");
    step(1'b0, 1'b0, 1'b0, 8'h81, 16'h0000, "rd81");
    check("mis_data", data_bus, 16'hBEEF);
    check("mis_set", err_misalign, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h83, 16'h5A5A, "wr83");
    step(1'b0, 1'b0, 1'b0, 8'h82, 16'h0000, "rd82");
    check("mis_wr_data", data_bus, 16'h5A5A);

    // Random traffic including odd addresses
    random_phase(200, 1'b1);
    check("mis_sticky", err_misalign, 1'b1);

    // Reboot, aborted by reset at addr 40, then full boot with A5A5
    bd_pulses = 0;
    for (int i = 0; i <= 32; i++)
      step(i == 32, 1'b1, 1'b0, 8'(2 * i), 16'h1111, "boot_abort");
    check("abort_mis_clr", err_misalign, 1'b0);
    for (int i = 0; i < 127; i++)
      step(1'b0, 1'b1, 1'b0, 8'(2 * i), 16'hA5A5, "reboot");
    step(1'b0, 1'b1, 1'b0, 8'hFE, 16'h0F0F, "last_a");
    step(1'b0, 1'b1, 1'b0, 8'hFE, 16'h0F0F, "last_b");
    step(1'b0, 1'b1, 1'b0, 8'hFE, 16'hA5A5, "last_c");
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "reboot_fall");
    step(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, "reboot_done");
    for (int i = 0; i < 128; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'(2 * i), 16'h0000, "a5");
      check("a5_word", data_bus, 16'hA5A5);
    end
    check("reboot_pulses", bd_pulses, 1);
    check("reboot_mis", err_misalign, 1'b0);
    check("reboot_wp", err_wp, 1'b0);
    check("reboot_cnt", wr_cnt, 16'd0);

    // Reset wins over a same-edge write; memory survives reset
    step(1'b0, 1'b0, 1'b1, 8'h86, 16'h1357, "pre_rst_wr");
    step(1'b1, 1'b0, 1'b1, 8'h84, 16'hDEAD, "rst_wr");
    step(1'b0, 1'b0, 1'b0, 8'h84, 16'h0000, "idle_rd");
    check("rst_prio", data_bus, 16'hA5A5);
    check("rst_cnt", wr_cnt, 16'd0);

    // IDLE write commits nothing
    step(1'b0, 1'b0, 1'b1, 8'h90, 16'h7777, "idle_wr");
    step(1'b0, 1'b0, 1'b0, 8'h90, 16'h0000, "idle_rd2");
    check("idle_wr_data", data_bus, 16'hA5A5);
    check("idle_wr_cnt", wr_cnt, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
